// File: rtl/spike_out_pkg.sv
// Shared helpers for the output spike path: address width and round-robin stepping.
package spike_out_pkg;

    // Width of a column address for n columns (n >= 2).
    function automatic int addr_width(input int n);
        return $clog2(n);
    endfunction

    // Next index in a round-robin ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// Show-ahead FIFO with registered full/empty flags and simultaneous push/pop,
// including push+pop while full (occupancy stays at DEPTH).
module spike_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    // Qualify requests: pops need data, pushes need room unless a pop frees a slot.
    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage write; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == (PTR_W+1)'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/spike_out_encoder.sv
// Captures per-column fire pulses with a timestamp, arbitrates them round-robin
// into an event FIFO and presents {addr, time} on a valid/ready stream.
module spike_out_encoder
    import spike_out_pkg::*;
#(
    parameter int NUM_COLS   = 2,
    parameter int TIME_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_COLS-1:0]           neuron_spike,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [addr_width(NUM_COLS)-1:0] out_addr,
    output logic [TIME_WIDTH-1:0]         out_time,
    output logic [DROP_WIDTH-1:0]         drop_count,
    output logic                          fifo_full
);
    localparam int ADDR_W = addr_width(NUM_COLS);
    localparam int SUM_W  = DROP_WIDTH + $clog2(NUM_COLS + 1);

    typedef struct packed {
        logic [ADDR_W-1:0]     addr;
        logic [TIME_WIDTH-1:0] ts;
    } spike_event_t;

    logic [TIME_WIDTH-1:0] time_q;
    logic [NUM_COLS-1:0]   pending_q, pending_d;
    logic [TIME_WIDTH-1:0] ts_q [NUM_COLS];
    logic [TIME_WIDTH-1:0] ts_d [NUM_COLS];
    logic [NUM_COLS-1:0]   drop_vec;
    logic [ADDR_W-1:0]     rr_q;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;
    logic [ADDR_W-1:0]     grant_idx;
    logic                  grant_any, push, pop;
    logic                  fifo_empty, fifo_full_w;
    spike_event_t          push_evt, head_evt;

    assign pop  = !fifo_empty && out_ready;
    assign push = grant_any && (!fifo_full_w || pop);

    // Round-robin search over pending columns starting at the pointer.
    always_comb begin
        logic [ADDR_W-1:0] scan;
        grant_any = 1'b0;
        grant_idx = '0;
        scan      = rr_q;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (!grant_any && pending_q[scan]) begin
                grant_any = 1'b1;
                grant_idx = scan;
            end
            scan = ADDR_W'(rr_next(int'(scan), NUM_COLS));
        end
    end

    assign push_evt.addr = grant_idx;
    assign push_evt.ts   = ts_q[grant_idx];

    // Per-column capture: a grant frees the slot so a same-cycle re-spike is kept.
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
        logic granted;
        assign granted = push && (grant_idx == ADDR_W'(gi));

        // Next pending/timestamp state and drop detection for this column.
        always_comb begin
            pending_d[gi] = pending_q[gi] && !granted;
            ts_d[gi]      = ts_q[gi];
            drop_vec[gi]  = 1'b0;
            if (neuron_spike[gi]) begin
                if (pending_d[gi]) begin
                    drop_vec[gi] = 1'b1;
                end else begin
                    pending_d[gi] = 1'b1;
                    ts_d[gi]      = time_q;
                end
            end
        end

        // Pending flag and timestamp register for this column.
        always_ff @(posedge clk) begin
            if (reset) begin
                pending_q[gi] <= 1'b0;
                ts_q[gi]      <= '0;
            end else begin
                pending_q[gi] <= pending_d[gi];
                ts_q[gi]      <= ts_d[gi];
            end
        end
    end

    // Saturating accumulation of all drops in this cycle.
    always_comb begin
        logic [SUM_W-1:0] total;
        total = SUM_W'(drop_q);
        for (int c = 0; c < NUM_COLS; c++) begin
            total = total + SUM_W'(drop_vec[c]);
        end
        drop_d = (total > SUM_W'({DROP_WIDTH{1'b1}})) ? {DROP_WIDTH{1'b1}}
                                                       : DROP_WIDTH'(total);
    end

    // Free-running timestamp, round-robin pointer and drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            time_q <= '0;
            rr_q   <= '0;
            drop_q <= '0;
        end else begin
            time_q <= time_q + 1'b1;
            drop_q <= drop_d;
            if (push) begin
                rr_q <= ADDR_W'(rr_next(int'(grant_idx), NUM_COLS));
            end
        end
    end

    spike_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(spike_event_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .rd_data   (head_evt),
        .full      (fifo_full_w),
        .empty     (fifo_empty)
    );

    // Head fields read as zero while nothing is buffered.
    assign out_valid  = !fifo_empty;
    assign out_addr   = fifo_empty ? '0 : head_evt.addr;
    assign out_time   = fifo_empty ? '0 : head_evt.ts;
    assign drop_count = drop_q;
    assign fifo_full  = fifo_full_w;

endmodule

// File: tb/tb_spike_out_encoder.sv
// Randomized bench for spike_out_encoder against a queue-based reference model.
module tb_spike_out_encoder;
    localparam int NC    = 4;
    localparam int TW    = 8;
    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int TMOD  = 1 << TW;
    localparam int DMAX  = (1 << DW) - 1;

    logic          clk;
    logic          reset;
    logic [NC-1:0] neuron_spike;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_addr;
    logic [TW-1:0] out_time;
    logic [DW-1:0] drop_count;
    logic          fifo_full;

    spike_out_encoder #(
        .NUM_COLS   (NC),
        .TIME_WIDTH (TW),
        .FIFO_DEPTH (DEPTH),
        .DROP_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .neuron_spike (neuron_spike),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_time     (out_time),
        .drop_count   (drop_count),
        .fifo_full    (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int unsigned m_cnt;
    bit          m_pend [NC];
    int unsigned m_ts   [NC];
    int unsigned m_rr;
    int unsigned m_drop;
    int unsigned mq_addr [$];
    int unsigned mq_time [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Apply one rising edge to the model with the inputs that were sampled.
    task automatic model_step(input bit rst, input bit [NC-1:0] sp, input bit rdy);
        bit pop;
        bit room;
        int g;
        int ndrop;
        if (rst) begin
            m_cnt = 0; m_rr = 0; m_drop = 0;
            for (int c = 0; c < NC; c++) begin m_pend[c] = 0; m_ts[c] = 0; end
            mq_addr.delete(); mq_time.delete();
            return;
        end
        pop  = (mq_addr.size() > 0) && rdy;
        room = (mq_addr.size() < DEPTH) || pop;
        g = -1;
        if (room) begin
            for (int i = 0; i < NC; i++) begin
                int c;
                c = (m_rr + i) % NC;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        if (pop) begin
            void'(mq_addr.pop_front());
            void'(mq_time.pop_front());
        end
        if (g >= 0) begin
            mq_addr.push_back(g);
            mq_time.push_back(m_ts[g]);
            m_pend[g] = 0;
            m_rr = (g + 1) % NC;
        end
        ndrop = 0;
        for (int c = 0; c < NC; c++) begin
            if (sp[c]) begin
                if (m_pend[c]) ndrop++;
                else begin m_pend[c] = 1; m_ts[c] = m_cnt; end
            end
        end
        m_drop = (m_drop + ndrop > DMAX) ? DMAX : m_drop + ndrop;
        m_cnt  = (m_cnt + 1) % TMOD;
    endtask

    // One cycle: check outputs on the falling edge, drive inputs, advance the model.
    task automatic drive_cycle(input bit rst, input bit [NC-1:0] sp, input bit rdy);
        bit has;
        @(negedge clk);
        has = mq_addr.size() > 0;
        check_eq("out_valid",  {31'd0, out_valid}, {31'd0, has});
        check_eq("out_addr",   {30'd0, out_addr}, has ? mq_addr[0] : 0);
        check_eq("out_time",   {24'd0, out_time}, has ? mq_time[0] : 0);
        check_eq("drop_count", {24'd0, drop_count}, m_drop);
        check_eq("fifo_full",  {31'd0, fifo_full}, {31'd0, mq_addr.size() == DEPTH});
        reset        = rst;
        neuron_spike = sp;
        out_ready    = rdy;
        if (has && rdy && !rst)
            $display("accept addr=%0d time=%0d drops=%0d", mq_addr[0], mq_time[0], m_drop);
        @(posedge clk);
        model_step(rst, sp, rdy);
    endtask

    task automatic run_random(input int n, input int sp_pct, input int rdy_pct, input int rst_pct);
        for (int k = 0; k < n; k++) begin
            bit [NC-1:0] sp;
            for (int c = 0; c < NC; c++) sp[c] = ($urandom_range(99, 0) < sp_pct);
            drive_cycle($urandom_range(99, 0) < rst_pct, sp,
                        $urandom_range(99, 0) < rdy_pct);
        end
    endtask

    initial begin
        reset = 1'b1; neuron_spike = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_step(1'b1, '0, 1'b0);

        // Directed opening: single spike, then a three-column burst, then cols 0,1.
        drive_cycle(1'b1, 4'b0000, 1'b0);
        repeat (5) drive_cycle(1'b0, 4'b0000, 1'b1);
        drive_cycle(1'b0, 4'b0100, 1'b1);
        repeat (4) drive_cycle(1'b0, 4'b0000, 1'b1);
        drive_cycle(1'b0, 4'b1011, 1'b1);
        repeat (5) drive_cycle(1'b0, 4'b0000, 1'b1);
        drive_cycle(1'b0, 4'b0011, 1'b1);
        repeat (4) drive_cycle(1'b0, 4'b0000, 1'b1);

        // Fill the FIFO with the consumer stalled, re-spike col 0, then drain.
        for (int c = 0; c < NC; c++) drive_cycle(1'b0, 4'b0001 << c, 1'b0);
        drive_cycle(1'b0, 4'b0001, 1'b0);
        repeat (3) drive_cycle(1'b0, 4'b0000, 1'b0);
        drive_cycle(1'b0, 4'b0001, 1'b0);
        repeat (8) drive_cycle(1'b0, 4'b0000, 1'b1);

        // Light traffic, then heavy traffic with back-pressure.
        run_random(400, 25, 80, 0);
        run_random(300, 60, 30, 0);

        // Column 1 firing every cycle: no drops while draining, saturation when stalled.
        drive_cycle(1'b1, 4'b0000, 1'b0);
        repeat (300) drive_cycle(1'b0, 4'b0010, 1'b1);
        repeat (300) drive_cycle(1'b0, 4'b0010, 1'b0);

        // Reset while events are buffered and pending, then random with sporadic resets.
        drive_cycle(1'b1, 4'b1111, 1'b0);
        repeat (3) drive_cycle(1'b0, 4'b0000, 1'b0);
        drive_cycle(1'b0, 4'b0100, 1'b0);
        repeat (3) drive_cycle(1'b0, 4'b0000, 1'b1);
        run_random(400, 40, 60, 2);
        repeat (10) drive_cycle(1'b0, 4'b0000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
